rggen_wide_register_common: RTL and testbench

// - Register front end for registers wider than the bus (DATA_WIDTH = N*BUS_WIDTH).
// - Adds atomic wide access: writes to low words are staged and committed together with the top word.
// - Reading word 0 snapshots the full value; later reads of the upper words are served from the snapshot.
// - Sits between a register_if slave port and the bit-field array.

---
 rtl/rggen_wide_register_common.sv | 170 +++++++++++++++++
 tb/tb_rggen_wide_register_common.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_wide_register_common.sv
// Register front end for registers wider than the bus: staged atomic writes and word-0 read snapshot.
// Optional macro RGGEN_STAGE_TIMEOUT_EN discards stale staged data after STAGE_TIMEOUT idle cycles.
module rggen_wide_register_common #(
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1,
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                     BUS_WIDTH      = 32,
    parameter int                     DATA_WIDTH     = 64,
    parameter int                     VALUE_WIDTH    = 64,
    parameter bit                     WRITE_STAGING  = 1'b1,
    parameter bit                     READ_SNAPSHOT  = 1'b1,
    parameter int                     STAGE_TIMEOUT  = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     register_valid,
    input  logic [1:0]               register_access,
    input  logic [ADDRESS_WIDTH-1:0] register_address,
    input  logic [BUS_WIDTH-1:0]     register_write_data,
    input  logic [BUS_WIDTH/8-1:0]   register_strobe,
    output logic                     register_active,
    output logic                     register_ready,
    output logic [1:0]               register_status,
    output logic [BUS_WIDTH-1:0]     register_read_data,
    output logic [VALUE_WIDTH-1:0]   register_value,
    input  logic                     i_additional_match,
    output logic                     bit_field_valid,
    output logic [DATA_WIDTH-1:0]    bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]    bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]    bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]    bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    bit_field_value,
    output logic                     o_stage_timeout
);
    localparam int WORDS    = DATA_WIDTH / BUS_WIDTH;
    localparam int BYTES    = BUS_WIDTH / 8;
    localparam bit STAGING  = WRITE_STAGING && (WORDS > 1);
    localparam bit SNAPSHOT = READ_SNAPSHOT && (WORDS > 1);
    localparam int IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW       = (WORDS > 1) ? DATA_WIDTH - BUS_WIDTH : 1;

    logic [WORDS-1:0]      match;
    logic [IW-1:0]         index;
    logic [BUS_WIDTH-1:0]  strb_bits;
    logic [DATA_WIDTH-1:0] write_rep;
    logic [DATA_WIDTH-1:0] word_strb;
    logic [DATA_WIDTH-1:0] word_ones;
    logic [BUS_WIDTH-1:0]  field_word;
    logic [BUS_WIDTH-1:0]  snap_word;
    logic                  write_access;
    logic                  read_access;
    logic                  low_stage;
    logic                  stage_write;
    logic                  commit;
    logic                  snap_load;
    logic                  snap_hit;
    logic                  expire;
    logic [SW-1:0]         stage_data;
    logic [SW-1:0]         stage_strb;
    logic [SW-1:0]         snap_data;
    logic                  snap_valid;

    // Any byte address inside a word's lane range selects that word.
    for (genvar g = 0; g < WORDS; g++) begin : g_decode
        localparam logic [ADDRESS_WIDTH-1:0] ADDR = ADDRESS_WIDTH'(OFFSET_ADDRESS + g * BYTES);
        assign match[g] = i_additional_match &&
                          (ADDRESS_WIDTH'(register_address - ADDR) < ADDRESS_WIDTH'(BYTES));
    end

    always_comb begin
        index = '0;
        for (int g = 0; g < WORDS; g++) begin
            if (match[g]) index = IW'(g);
        end
        for (int i = 0; i < BUS_WIDTH; i++) begin
            strb_bits[i] = register_strobe[i / 8];
        end
    end

    assign register_active = |match;
    assign register_ready  = register_active;
    assign register_status = 2'b00;
    assign register_value  = VALUE_WIDTH'(bit_field_value);

    assign write_access = register_valid && register_active && register_access[0];
    assign read_access  = register_valid && register_active && register_access[1] && !register_access[0];
    assign low_stage    = STAGING && (index != IW'(WORDS - 1));
    assign stage_write  = write_access && low_stage && WRITABLE;
    assign commit       = write_access && !low_stage;
    assign snap_load    = read_access && SNAPSHOT && READABLE && (index == '0);
    assign snap_hit     = read_access && SNAPSHOT && (index != '0) && snap_valid;

    assign write_rep  = {WORDS{register_write_data}};
    assign word_strb  = DATA_WIDTH'(strb_bits) << (int'(index) * BUS_WIDTH);
    assign word_ones  = DATA_WIDTH'({BUS_WIDTH{1'b1}}) << (int'(index) * BUS_WIDTH);
    assign field_word = BUS_WIDTH'(bit_field_read_data >> (int'(index) * BUS_WIDTH));
    assign snap_word  = BUS_WIDTH'(snap_data >> ((int'(index) - 1) * BUS_WIDTH));

    always_comb begin
        bit_field_valid      = 1'b0;
        bit_field_read_mask  = '0;
        bit_field_write_mask = '0;
        bit_field_write_data = write_rep;
        register_read_data   = '0;
        if (commit) begin
            bit_field_valid = 1'b1;
            if (STAGING) begin
                bit_field_write_data = DATA_WIDTH'({register_write_data, stage_data});
                if (WRITABLE) bit_field_write_mask = DATA_WIDTH'({strb_bits, stage_strb});
            end else if (WRITABLE) begin
                bit_field_write_mask = word_strb;
            end
        end else if (read_access && !snap_hit) begin
            // Snapshotting reads take the whole register so upper words match word 0.
            bit_field_valid = 1'b1;
            if (READABLE) bit_field_read_mask = snap_load ? '1 : word_ones;
        end
        if (READABLE) register_read_data = snap_hit ? snap_word : field_word;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_data <= '0;
            stage_strb <= '0;
            snap_data  <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (stage_write) begin
                stage_data <= (stage_data & ~word_strb[SW-1:0]) | (write_rep[SW-1:0] & word_strb[SW-1:0]);
                stage_strb <= stage_strb | word_strb[SW-1:0];
            end else if (commit || expire) begin
                stage_strb <= '0;
            end
            if (commit) begin
                snap_valid <= 1'b0;
            end else if (snap_load) begin
                snap_data  <= SW'(bit_field_read_data >> BUS_WIDTH);
                snap_valid <= 1'b1;
            end
        end
    end

`ifdef RGGEN_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(STAGE_TIMEOUT + 1);
    logic [CW-1:0] timeout_cnt;

    // Expiry fires on the edge that would bring the idle count to STAGE_TIMEOUT.
    assign expire = STAGING && (stage_strb != '0) && !commit && !stage_write &&
                    (timeout_cnt == CW'(STAGE_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_cnt     <= '0;
            o_stage_timeout <= 1'b0;
        end else begin
            o_stage_timeout <= expire;
            if (stage_write || commit || expire || (stage_strb == '0)) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end
`else
    assign expire          = 1'b0;
    assign o_stage_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rggen_wide_register_common.sv
// Randomized bench for rggen_wide_register_common against a byte-level staging/snapshot model.
module tb_rggen_wide_register_common;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int DW = 64;
`ifdef RGGEN_STAGE_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          reg_valid = 1'b0;
    logic [1:0]    reg_access = 2'b10;
    logic [AW-1:0] reg_address = '0;
    logic [BW-1:0] reg_wdata = '0;
    logic [3:0]    reg_strobe = '0;
    logic          reg_active, reg_ready;
    logic [1:0]    reg_status;
    logic [BW-1:0] reg_rdata;
    logic [DW-1:0] reg_value;
    logic          add_match = 1'b1;
    logic          f_valid;
    logic [DW-1:0] f_rmask, f_wmask, f_wdata;
    logic [DW-1:0] field = '0;
    logic          stage_timeout;

    always #5 clk = ~clk;

    rggen_wide_register_common #(
        .ADDRESS_WIDTH  (AW),
        .OFFSET_ADDRESS (8'h10),
        .BUS_WIDTH      (BW),
        .DATA_WIDTH     (DW),
        .VALUE_WIDTH    (DW),
        .STAGE_TIMEOUT  ((TMO > 0) ? TMO : 256)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .register_valid       (reg_valid),
        .register_access      (reg_access),
        .register_address     (reg_address),
        .register_write_data  (reg_wdata),
        .register_strobe      (reg_strobe),
        .register_active      (reg_active),
        .register_ready       (reg_ready),
        .register_status      (reg_status),
        .register_read_data   (reg_rdata),
        .register_value       (reg_value),
        .i_additional_match   (add_match),
        .bit_field_valid      (f_valid),
        .bit_field_read_mask  (f_rmask),
        .bit_field_write_mask (f_wmask),
        .bit_field_write_data (f_wdata),
        .bit_field_read_data  (field),
        .bit_field_value      (field),
        .o_stage_timeout      (stage_timeout)
    );

    // Model: pending bytes of word 0, snapshot of word 1, idle age of pending data.
    logic [7:0]  stg_byte [4];
    bit          stg_vld  [4];
    logic [31:0] snap;
    bit          snap_ok;
    int          age;
    bit          exp_pulse;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", tag, act, exp);
    endtask

    task automatic model_clear();
        for (int b = 0; b < 4; b++) begin
            stg_vld[b]  = 1'b0;
            stg_byte[b] = '0;
        end
        snap_ok   = 1'b0;
        snap      = '0;
        age       = 0;
        exp_pulse = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        reg_valid = 1'b0;
        @(negedge clk);
        chk("rst_timeout", stage_timeout, 1'b0);
        chk("rst_status", reg_status, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    // One bus cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input bit vld, input logic [7:0] addr, input bit wr,
                        input logic [31:0] wd, input logic [3:0] st, input bit am);
        bit          hit, w, stg_w, commit, e_v, any;
        logic [63:0] e_wm, e_wd, e_rm;
        logic [31:0] e_rd;
        reg_valid   = vld;
        reg_access  = wr ? 2'b11 : 2'b10;
        reg_address = addr;
        reg_wdata   = wd;
        reg_strobe  = st;
        add_match   = am;
        hit = am && (addr[7:2] == 6'h4 || addr[7:2] == 6'h5);
        w   = addr[2];
        e_v = 0; e_wm = '0; e_wd = '0; e_rm = '0; e_rd = '0; stg_w = 0; commit = 0;
        if (vld && hit) begin
            if (wr && !w) begin
                stg_w = 1;
            end else if (wr) begin
                e_v = 1; commit = 1;
                for (int b = 0; b < 4; b++) begin
                    if (stg_vld[b]) begin e_wm[b*8 +: 8] = 8'hFF; e_wd[b*8 +: 8] = stg_byte[b]; end
                    if (st[b]) begin e_wm[32+b*8 +: 8] = 8'hFF; e_wd[32+b*8 +: 8] = wd[b*8 +: 8]; end
                end
            end else if (!w) begin
                e_v = 1; e_rm = '1; e_rd = field[31:0];
            end else if (snap_ok) begin
                e_rd = snap;
            end else begin
                e_v = 1; e_rm = 64'hFFFFFFFF_00000000; e_rd = field[63:32];
            end
        end
        @(negedge clk);
        chk("active", reg_active, hit);
        chk("ready", reg_ready, hit);
        chk("fvalid", f_valid, e_v);
        if (e_v) begin
            chk("wmask", f_wmask, e_wm);
            chk("wdata", f_wdata & f_wmask, e_wd & e_wm);
            chk("rmask", f_rmask, e_rm);
        end
        if (vld && hit && !wr) chk("rdata", reg_rdata, e_rd);
        chk("timeout", stage_timeout, exp_pulse);
        @(posedge clk);
        exp_pulse = 1'b0;
        any = stg_vld[0] || stg_vld[1] || stg_vld[2] || stg_vld[3];
        if (stg_w) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) begin stg_byte[b] = wd[b*8 +: 8]; stg_vld[b] = 1'b1; end
            end
            age = 0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) stg_vld[b] = 1'b0;
            snap_ok = 1'b0;
            age = 0;
        end else if (any && TMO > 0) begin
            age++;
            if (age == TMO) begin
                for (int b = 0; b < 4; b++) stg_vld[b] = 1'b0;
                age = 0;
                exp_pulse = 1'b1;
            end
        end
        if (vld && hit && !wr && !w) begin
            snap = field[63:32];
            snap_ok = 1'b1;
        end
        #1 reg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=%0d exp=finished", n_chk);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0] a;
        int         r;
        model_clear();
        #2 do_reset();
        step(0, 8'h10, 0, '0, 4'h0, 1);
        // Atomic write then top-word commit.
        step(1, 8'h10, 1, 32'hAAAA5555, 4'hF, 1);
        step(1, 8'h14, 1, 32'h12345678, 4'hF, 1);
        // Snapshot read survives a field change.
        field = 64'hDEADBEEF_00000001;
        step(1, 8'h10, 0, '0, 4'hF, 1);
        field = '0;
        step(1, 8'h14, 0, '0, 4'hF, 1);
        chk("value", reg_value, field);
        // Top-only commit, then snapshot cleared so word 1 is read live.
        step(1, 8'h14, 1, 32'hCAFEF00D, 4'hF, 1);
        field = 64'h01234567_89ABCDEF;
        step(1, 8'h14, 0, '0, 4'hF, 1);
        // Byte merge across two staging writes.
        step(1, 8'h10, 1, 32'h000011AA, 4'b0011, 1);
        step(1, 8'h10, 1, 32'h22BB0000, 4'b1100, 1);
        step(1, 8'h10, 0, '0, 4'hF, 1);
        step(1, 8'h14, 1, 32'h0, 4'hF, 1);
        // Reset discards staging.
        step(1, 8'h10, 1, 32'h55555555, 4'hF, 1);
        do_reset();
        step(1, 8'h14, 1, 32'h77777777, 4'hF, 1);
        // Idle run after staging: expires only when the timeout is built in.
        step(1, 8'h10, 1, 32'h13579BDF, 4'hF, 1);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 0, '0, 4'h0, 1);
        step(1, 8'h14, 1, 32'h2468ACE0, 4'hF, 1);
        // Decode qualifier and out-of-range addresses.
        step(1, 8'h10, 1, 32'h11111111, 4'hF, 0);
        step(1, 8'h18, 1, 32'h11111111, 4'hF, 1);
        step(1, 8'h14, 1, 32'h99999999, 4'h5, 1);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      a = 8'h10 + 8'($urandom_range(0, 3));
            else if (r < 8) a = 8'h14 + 8'($urandom_range(0, 3));
            else if (r == 8) a = 8'h18;
            else            a = 8'h0C;
            if ($urandom_range(0, 7) == 0) field = {$urandom, $urandom};
            step($urandom_range(0, 5) != 0, a, 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom), $urandom_range(0, 9) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
